bin_a_bcd_seq: RTL

- Parametrised, sequential binary-to-BCD converter using iterative double-dabble: add 3 to any BCD digit ≥5, then shift one bit per clock.
- Successor to the 4-bit combinational converter; it handles any input width WIDTH.
- Adds a valid/ready handshake on both sides and a leading-zero significance mask for 7-segment blanking.
- Sits between binary datapath results and the display digit multiplexer.

---
 rtl/bin_a_bcd_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bin_a_bcd_seq.sv
// Sequential binary-to-BCD converter (iterative double-dabble, one bit per clock)
// with valid/ready handshakes and a leading-zero significance mask.
module bin_a_bcd_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  busy
);

    localparam int unsigned SR_W  = WIDTH + 4 * DIGITS;
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    // Minimum digit count: ceil(WIDTH * log10(2)), done in fixed point (log2(10) ~ 3.321928)
    localparam longint unsigned W_SCALED   = 64'(WIDTH) * 64'd1000000;
    localparam int unsigned     MIN_DIGITS = 32'((W_SCALED + 64'd3321927) / 64'd3321928);

    // Reject configurations whose largest input does not fit in DIGITS decimal digits
    if (DIGITS < MIN_DIGITS) begin : g_bad_digits
        $error("bin_a_bcd_seq: DIGITS=%0d too small for WIDTH=%0d (need %0d)",
               DIGITS, WIDTH, MIN_DIGITS);
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_last;
    logic [SR_W-1:0]    r_sreg;
    logic [CNT_W-1:0]   r_cnt;
    logic [SR_W-1:0]    w_adj;
    logic [SR_W-1:0]    w_shifted;
    logic [BCD_W-1:0]   w_bcd_res;
    logic [DIGITS-1:0]  w_den;

    assign in_ready = (r_state == S_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus accept / final-shift strobes
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = S_SHIFT;
                    w_accept    = 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_DONE;
                    w_last      = 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Add-3 correction on each BCD digit >= 5 (no inter-digit carry), then shift left
    always_comb begin
        w_adj = r_sreg;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (r_sreg[WIDTH + 4*i +: 4] >= 4'd5) begin
                w_adj[WIDTH + 4*i +: 4] = r_sreg[WIDTH + 4*i +: 4] + 4'd3;
            end
        end
        w_shifted = w_adj << 1;
        w_bcd_res = w_shifted[SR_W-1:WIDTH];
    end

    // Significance mask: a digit is shown if it or any higher digit is nonzero
    always_comb begin
        w_den = '0;
        w_den[DIGITS-1] = |w_bcd_res[4*(DIGITS-1) +: 4];
        for (int i = int'(DIGITS) - 2; i >= 0; i--) begin
            w_den[i] = w_den[i+1] | (|w_bcd_res[4*i +: 4]);
        end
        w_den[0] = 1'b1;
    end

    // Shift register, bit counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg    <= '0;
            r_cnt     <= '0;
            bcd_out   <= '0;
            digit_en  <= DIGITS'(1);
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            out_valid <= (w_state_nxt == S_DONE);
            busy      <= (w_state_nxt == S_SHIFT);
            if (w_accept) begin
                r_sreg <= {{BCD_W{1'b0}}, bin_in};
                r_cnt  <= CNT_W'(WIDTH);
            end else if (r_state == S_SHIFT) begin
                r_sreg <= w_shifted;
                r_cnt  <= r_cnt - CNT_W'(1);
            end
            if (w_last) begin
                bcd_out  <= w_bcd_res;
                digit_en <= w_den;
            end
        end
    end

endmodule
